// File: rtl/isa_pkg.sv
// Shared ISA definitions: opcode/funct constants, ALU operation set, decode and ALU helpers.
// Later pipeline stages reuse these so that every stage decodes the same way.
package isa_pkg;

  localparam logic [5:0] OPC_RTYPE = 6'h00;
  localparam logic [5:0] OPC_ADDI  = 6'h08;
  localparam logic [5:0] OPC_ANDI  = 6'h0C;

  localparam logic [5:0] FN_SLL = 6'h00;
  localparam logic [5:0] FN_ADD = 6'h20;
  localparam logic [5:0] FN_SUB = 6'h22;
  localparam logic [5:0] FN_AND = 6'h24;
  localparam logic [5:0] FN_OR  = 6'h25;
  localparam logic [5:0] FN_SLT = 6'h2A;

  typedef enum logic [2:0] {
    ALU_NOP,
    ALU_ADD,
    ALU_SUB,
    ALU_AND,
    ALU_OR,
    ALU_SLT,
    ALU_SLL
  } alu_op_e;

  typedef struct packed {
    alu_op_e     op;
    logic [4:0]  dest;
    logic        we;
    logic        use_imm;
    logic [31:0] imm;
  } decode_t;

  function automatic decode_t decode_instr(input logic [31:0] instr);
    decode_t d;
    d.op      = ALU_NOP;
    d.dest    = 5'd0;
    d.we      = 1'b0;
    d.use_imm = 1'b0;
    d.imm     = 32'd0;
    case (instr[31:26])
      OPC_RTYPE: begin
        d.dest = instr[15:11];
        case (instr[5:0])
          FN_ADD:  d.op = ALU_ADD;
          FN_SUB:  d.op = ALU_SUB;
          FN_AND:  d.op = ALU_AND;
          FN_OR:   d.op = ALU_OR;
          FN_SLT:  d.op = ALU_SLT;
          FN_SLL:  d.op = ALU_SLL;
          default: d.op = ALU_NOP;
        endcase
      end
      OPC_ADDI: begin
        d.op      = ALU_ADD;
        d.dest    = instr[20:16];
        d.use_imm = 1'b1;
        d.imm     = {{16{instr[15]}}, instr[15:0]};
      end
      OPC_ANDI: begin
        d.op      = ALU_AND;
        d.dest    = instr[20:16];
        d.use_imm = 1'b1;
        d.imm     = {16'd0, instr[15:0]};
      end
      default: d.op = ALU_NOP;
    endcase
    // Unsupported encodings retire with no destination; r0 targets never count as writes.
    if (d.op == ALU_NOP) d.dest = 5'd0;
    d.we = (d.op != ALU_NOP) && (d.dest != 5'd0);
    return d;
  endfunction

  function automatic logic [31:0] alu_compute(input alu_op_e op, input logic [31:0] a,
                                              input logic [31:0] b, input logic [4:0] shamt);
    logic [31:0] r;
    case (op)
      ALU_ADD: r = a + b;
      ALU_SUB: r = a - b;
      ALU_AND: r = a & b;
      ALU_OR:  r = a | b;
      ALU_SLT: r = {31'd0, ($signed(a) < $signed(b))};
      ALU_SLL: r = b << shamt;
      default: r = 32'd0;
    endcase
    return r;
  endfunction

endpackage

// File: rtl/instruction_execute_if.sv
// Fetch-to-retire bus of the execute stage: instruction in, retirement results out.
interface instruction_execute_if (
  input logic clk
);
  logic [31:0] instruction_code;
  logic [31:0] alu_result;
  logic [4:0]  write_reg;
  logic        write_en;
  logic        zero;

  modport master (
    input  clk,
    output instruction_code,
    input  alu_result,
    input  write_reg,
    input  write_en,
    input  zero
  );

  modport slave (
    input  clk,
    input  instruction_code,
    output alu_result,
    output write_reg,
    output write_en,
    output zero
  );
endinterface

// File: rtl/register_file.sv
// 32x32 register file: two combinational read ports, one synchronous write port,
// synchronous active-low clear. Register 0 always reads zero and ignores writes.
module register_file (
  input  logic        clk,
  input  logic        reset,
  input  logic [4:0]  rd_addr_a,
  output logic [31:0] rd_data_a,
  input  logic [4:0]  rd_addr_b,
  output logic [31:0] rd_data_b,
  input  logic        wr_en,
  input  logic [4:0]  wr_addr,
  input  logic [31:0] wr_data
);
  logic [31:0] mem_reg [32];

  always_ff @(posedge clk) begin
    if (!reset) begin
      for (int i = 0; i < 32; i++) mem_reg[i] <= 32'd0;
    end else if (wr_en && (wr_addr != 5'd0)) begin
      mem_reg[wr_addr] <= wr_data;
    end
  end

  assign rd_data_a = (rd_addr_a == 5'd0) ? 32'd0 : mem_reg[rd_addr_a];
  assign rd_data_b = (rd_addr_b == 5'd0) ? 32'd0 : mem_reg[rd_addr_b];
endmodule

// File: rtl/instruction_execute.sv
// Two-stage decode/execute pipeline: stage 1 decodes and reads operands, stage 2 runs the
// ALU, writes the register file and registers the retirement outputs.
module instruction_execute
  import isa_pkg::*;
#(
  parameter int unsigned FORWARD_EN = 1
) (
  input  logic        clk,
  input  logic        reset,
  input  logic [31:0] Instruction_Code,
  output logic [31:0] ALU_Result,
  output logic [4:0]  Write_Reg,
  output logic        Write_En,
  output logic        Zero
);
  localparam bit FWD = (FORWARD_EN != 32'd0);

  logic [4:0]  rs;
  logic [4:0]  rt;
  logic [4:0]  shamt;
  decode_t     dec;
  logic [31:0] rf_a;
  logic [31:0] rf_b;
  logic [31:0] op_a;
  logic [31:0] op_b;
  logic [31:0] alu_value;

  alu_op_e     s1_op_reg;
  logic [4:0]  s1_dest_reg;
  logic [4:0]  s1_shamt_reg;
  logic        s1_we_reg;
  logic [31:0] s1_a_reg;
  logic [31:0] s1_b_reg;

  assign rs    = Instruction_Code[25:21];
  assign rt    = Instruction_Code[20:16];
  assign shamt = Instruction_Code[10:6];
  assign dec   = decode_instr(Instruction_Code);

  register_file u_register_file (
    .clk       (clk),
    .reset     (reset),
    .rd_addr_a (rs),
    .rd_data_a (rf_a),
    .rd_addr_b (rt),
    .rd_data_b (rf_b),
    .wr_en     (s1_we_reg),
    .wr_addr   (s1_dest_reg),
    .wr_data   (alu_value)
  );

  assign alu_value = alu_compute(s1_op_reg, s1_a_reg, s1_b_reg, s1_shamt_reg);

  // Bypass the instruction one ahead; s1_we_reg is never set for r0, so r0 stays zero.
  always_comb begin
    op_a = rf_a;
    op_b = rf_b;
    if (FWD && s1_we_reg) begin
      if (s1_dest_reg == rs) op_a = alu_value;
      if (s1_dest_reg == rt) op_b = alu_value;
    end
  end

  always_ff @(posedge clk) begin
    if (!reset) begin
      s1_op_reg    <= ALU_NOP;
      s1_dest_reg  <= 5'd0;
      s1_shamt_reg <= 5'd0;
      s1_we_reg    <= 1'b0;
      s1_a_reg     <= 32'd0;
      s1_b_reg     <= 32'd0;
      ALU_Result   <= 32'd0;
      Write_Reg    <= 5'd0;
      Write_En     <= 1'b0;
      Zero         <= 1'b0;
    end else begin
      s1_op_reg    <= dec.op;
      s1_dest_reg  <= dec.dest;
      s1_shamt_reg <= shamt;
      s1_we_reg    <= dec.we;
      s1_a_reg     <= op_a;
      s1_b_reg     <= dec.use_imm ? dec.imm : op_b;
      ALU_Result   <= alu_value;
      Write_Reg    <= s1_dest_reg;
      Write_En     <= s1_we_reg;
      Zero         <= s1_we_reg && (alu_value == 32'd0);
    end
  end
endmodule

// File: doc/instruction_execute.md
INSTRUCTION_EXECUTE -- requirements
Module: instruction_execute

Interface
REQ-001 The block SHALL have parameter FORWARD_EN, default 1, which enables the ALU-to-read-port bypass; 0 disables it.
REQ-002 The block SHALL have port clk, input, 1 bit: the single clock; all state updates on its rising edge.
REQ-003 The block SHALL have port reset, input, 1 bit: synchronous, active-low reset sampled on rising clk.
REQ-004 The block SHALL have port Instruction_Code, input, 32 bits: instruction from the fetch stage, one per cycle.
REQ-005 The block SHALL have port ALU_Result, output, 32 bits: registered result of the retiring instruction.
REQ-006 The block SHALL have port Write_Reg, output, 5 bits: registered destination index of the retiring instruction.
REQ-007 The block SHALL have port Write_En, output, 1 bit: registered flag, high when the retiring instruction wrote a register.
REQ-008 The block SHALL have port Zero, output, 1 bit: registered flag, high when ALU_Result == 0 and Write_En is high.

Function
REQ-009 Field decode SHALL be: opcode [31:26], rs [25:21], rt [20:16], rd [15:11], shamt [10:6], funct [5:0], imm [15:0].
REQ-010 Supported R-type (opcode 0x00) instructions SHALL be: funct 0x20 add, 0x22 sub, 0x24 and, 0x25 or, 0x2A slt (signed compare; result 1 or 0), and 0x00 sll (rt << shamt); dest = rd.
REQ-011 Supported I-type instructions SHALL be: 0x08 addi (sign-extended imm) and 0x0C andi (zero-extended imm); dest = rt.
REQ-012 Any other opcode/funct SHALL be a NOP: no register write and Write_En = 0 when it retires.
REQ-013 All arithmetic SHALL be 32-bit two's complement with wrap-around; no overflow trap.
REQ-014 Stage 1 (decode): in cycle C0 the block SHALL decode the instruction, read rs/rt from the register file, and capture op, dest, operands and a write flag on edge E1.
REQ-015 Stage 2 (execute/writeback): in cycle C1 the block SHALL compute the ALU combinationally and, on edge E2, write the register file and update ALU_Result, Write_Reg, Write_En and Zero.
REQ-016 Latency SHALL be 2 clk edges from instruction presentation to visible outputs; throughput SHALL be one instruction per cycle, with no stalls.
REQ-017 Register 0 SHALL always read 0; writes with dest 0 SHALL be discarded, and Write_En SHALL be 0 for them.
REQ-018 When FORWARD_EN = 1 and the stage-2 instruction writes register r (r != 0), a stage-1 read of r SHALL return the stage-2 ALU value instead of the register-file value.
REQ-019 When an instruction in cycle C0 reads a register written by the instruction from C-2, the read SHALL return the written value; no bypass is needed for this case.
REQ-020 When rs == rt, both operands SHALL receive the same (possibly forwarded) value.

Reset
REQ-021 While reset = 0 at a rising edge, the block SHALL clear all 32 registers, the stage-1 register and the outputs (ALU_Result = 0, Write_Reg = 0, Write_En = 0, Zero = 0), and SHALL ignore Instruction_Code.
REQ-022 A reset asserted mid-stream SHALL discard both in-flight instructions, with no partial register write.
REQ-023 The first instruction presented with reset = 1 SHALL retire 2 edges later.

Structure
REQ-024 Opcode and funct constants and the ALU-operation enumeration SHALL reside in a shared package, isa_pkg, reused by later stages.
REQ-025 The register file SHALL be a sub-module, register_file: 32x32 storage, 2 combinational read ports, 1 synchronous write port, synchronous active-low clear.

Verification
REQ-026 Scenario: 0x20010005 (addi r1,r0,5), then 0x20020003, then 0x00221820 (add r3,r1,r2) -> third retire shows ALU_Result = 8, Write_Reg = 3, Write_En = 1.
REQ-027 Scenario: back-to-back 0x20010005, then 0x00211820 (add r3,r1,r1) -> ALU_Result = 10; with FORWARD_EN = 0, ALU_Result = 0.
REQ-028 Scenario: after r1 = 5 and r2 = 3, issue 0x00222022 (sub r4) -> ALU_Result = 2; then 0x0041282A (slt r5,r2,r1) -> ALU_Result = 1.
REQ-029 Scenario: 0x2006FFFF (addi r6,-1) then 0x30C700F0 (andi r7) -> ALU_Result 0xFFFFFFFF, then 0x000000F0; 0x00014080 (sll r8,r1,2) with r1 = 5 -> ALU_Result = 20.
REQ-030 Scenario: 0x20000007 (addi r0,7), then 0x00001020 (add r2,r0,r0) -> Write_En = 0 for the first; ALU_Result = 0 and Zero = 1 for the second; opcode 0x3F -> Write_En = 0.
REQ-031 Scenario: assert reset for 1 cycle while 2 instructions are in flight -> outputs are 0 next edge, all registers read 0, and the in-flight writes are lost.
